// File: rtl/digi_att_pkg.sv
// Shared types and limits for the serial digital attenuator chain driver.
// Holds the controller state encoding and the counter widths sized for the
// largest supported configuration (16 channels, 16 gain bits, 8 pad bits,
// half-period divider up to 255).
package digi_att_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } att_state_t;

    localparam int MAX_N_CH    = 16;
    localparam int MAX_GAIN_W  = 16;
    localparam int MAX_PAD_W   = 8;
    localparam int MAX_CLK_DIV = 255;

    // Bit counter must reach MAX_GAIN_W + MAX_PAD_W - 1 = 23.
    localparam int BIT_CNT_W = 5;
    // Half-period divider counter must reach MAX_CLK_DIV - 1.
    localparam int DIV_CNT_W = 8;

endpackage

// File: rtl/att_sclk_gen.sv
// Half-period timebase for the attenuator serial clock.
// While run is high a counter walks 0..CLK_DIV-1; tick marks the last cycle
// of each half-period and phase flips after it (0 = SCLK low, 1 = SCLK high).
// pre_tick marks the cycle before tick and lets the controller end the
// inter-channel gap one cycle early so the selection cycle fills the slot.
// Dropping run restarts the timebase at phase 0, count 0.
module att_sclk_gen
    import digi_att_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic ATT_CLK,
    input  logic ATT_RST,
    input  logic run,
    output logic tick,
    output logic pre_tick,
    output logic phase
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [DIV_CNT_W-1:0] DIV_PRE  = DIV_CNT_W'(CLK_DIV - 2);

    logic [DIV_CNT_W-1:0] cnt_reg;
    logic                 phase_reg;

    // Divider counter and SCLK phase, held cleared whenever the timebase is idle.
    always_ff @(posedge ATT_CLK or posedge ATT_RST) begin
        if (ATT_RST) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (!run) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign tick     = run && (cnt_reg == DIV_LAST);
    assign pre_tick = run && (CLK_DIV > 1) && (cnt_reg == DIV_PRE);
    assign phase    = phase_reg;

endmodule

// File: rtl/digi_att_chain.sv
// Serial programming controller for a chain of digital step attenuators.
// A Start strobe snapshots all gains and a channel mask; each masked channel
// is then shifted out MSB first (gain bits followed by zero padding) on
// ATT_SCLK/ATT_DATA and latched with its own ATT_LE pulse, lowest index
// first. The selection cycle between channels (and the Done cycle after the
// last one) occupies the final slot of the inter-channel gap, so every
// channel costs CLK_DIV*(2W+2) cycles.
// Optional feature macro DIGI_ATT_SKIP_UNCHANGED_EN: keep the last latched
// gain per channel and skip masked channels whose requested gain is equal.
module digi_att_chain
    import digi_att_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int GAIN_W  = 6,
    parameter int PAD_W   = 2,
    parameter int CLK_DIV = 2
) (
    input  logic                     ATT_CLK,
    input  logic                     ATT_RST,
    input  logic [N_CH*GAIN_W-1:0]   ATT_Gain,
    input  logic [N_CH-1:0]          ATT_Mask,
    input  logic                     ATT_Start,
    output logic                     ATT_Busy,
    output logic                     ATT_Done,
    output logic                     ATT_SCLK,
    output logic                     ATT_DATA,
    output logic [N_CH-1:0]          ATT_LE
);

    localparam int W    = GAIN_W + PAD_W;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(W - 1);

    att_state_t             state_reg, state_next;
    logic [N_CH*GAIN_W-1:0] gain_reg, gain_next;
    logic [N_CH-1:0]        pending_reg, pending_next;
    logic [N_CH-1:0]        eff_pending;
    logic [CH_W-1:0]        cur_ch_reg, cur_ch_next;
    logic [CH_W-1:0]        sel_idx;
    logic [W-1:0]           shift_reg, shift_next;
    logic [W-1:0]           sel_word;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic                   sel_any;
    logic                   div_run, div_tick, div_pre_tick, div_phase;
    logic [GAIN_W-1:0]      snap_gain [N_CH];

    att_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .ATT_CLK  (ATT_CLK),
        .ATT_RST  (ATT_RST),
        .run      (div_run),
        .tick     (div_tick),
        .pre_tick (div_pre_tick),
        .phase    (div_phase)
    );

    assign div_run = (state_reg == ST_SHIFT) || (state_reg == ST_LATCH) ||
                     (state_reg == ST_GAP);

    // Per-channel view of the snapshot and one-hot latch enable decode.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign snap_gain[gi] = gain_reg[gi*GAIN_W +: GAIN_W];
            assign ATT_LE[gi]    = (state_reg == ST_LATCH) && (cur_ch_reg == CH_W'(gi));
        end
    endgenerate

`ifdef DIGI_ATT_SKIP_UNCHANGED_EN
    logic [GAIN_W-1:0] shadow_reg [N_CH];
    logic [N_CH-1:0]   unchanged;

    // Remember the gain each channel was last latched with.
    always_ff @(posedge ATT_CLK or posedge ATT_RST) begin
        if (ATT_RST) begin
            for (int c = 0; c < N_CH; c++) shadow_reg[c] <= '0;
        end else if (state_reg == ST_LATCH && div_tick) begin
            for (int c = 0; c < N_CH; c++) begin
                if (cur_ch_reg == CH_W'(c)) shadow_reg[c] <= snap_gain[c];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_skip
            assign unchanged[gi] = (snap_gain[gi] == shadow_reg[gi]);
        end
    endgenerate

    assign eff_pending = pending_reg & ~unchanged;
`else
    assign eff_pending = pending_reg;
`endif

    // Lowest-index pending channel wins.
    always_comb begin
        sel_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eff_pending[i]) sel_idx = CH_W'(i);
        end
    end

    assign sel_any  = |eff_pending;
    assign sel_word = W'(snap_gain[sel_idx]) << PAD_W;

    // Controller next-state, snapshot, channel selection and shifter.
    always_comb begin
        state_next   = state_reg;
        gain_next    = gain_reg;
        pending_next = pending_reg;
        cur_ch_next  = cur_ch_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ATT_Start) begin
                    gain_next    = ATT_Gain;
                    pending_next = ATT_Mask;
                    state_next   = ST_SEL;
                end
            end
            ST_SEL: begin
                if (sel_any) begin
                    cur_ch_next           = sel_idx;
                    shift_next            = sel_word;
                    bit_cnt_next          = '0;
                    pending_next[sel_idx] = 1'b0;
                    state_next            = ST_SHIFT;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_SHIFT: begin
                // Advance only at the end of the SCLK-high half so DATA moves while SCLK is low.
                if (div_tick && div_phase) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = ST_LATCH;
                    end else begin
                        shift_next   = shift_reg << 1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (div_tick) begin
                    if (CLK_DIV == 1) begin
                        state_next = sel_any ? ST_SEL : ST_DONE;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (div_pre_tick) begin
                    state_next = sel_any ? ST_SEL : ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any transfer in progress.
    always_ff @(posedge ATT_CLK or posedge ATT_RST) begin
        if (ATT_RST) begin
            state_reg   <= ST_IDLE;
            gain_reg    <= '0;
            pending_reg <= '0;
            cur_ch_reg  <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gain_reg    <= gain_next;
            pending_reg <= pending_next;
            cur_ch_reg  <= cur_ch_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    assign ATT_Busy = (state_reg != ST_IDLE);
    assign ATT_Done = (state_reg == ST_DONE);
    assign ATT_SCLK = (state_reg == ST_SHIFT) && div_phase;
    assign ATT_DATA = (state_reg == ST_SHIFT) && shift_reg[W-1];

endmodule

// File: tb/tb_digi_att_chain.sv
// Scoreboard bench for digi_att_chain at default parameters. Stimulus pushes
// the expected latch events (channel, serial word) and completion events
// (latency from Start, SCLK rising-edge count) into queues; a monitor on the
// falling clock edge reassembles serial words and pops/compares whenever the
// DUT pulses ATT_LE or ATT_Done.
module tb_digi_att_chain;

    localparam int N_CH    = 4;
    localparam int GAIN_W  = 6;
    localparam int PAD_W   = 2;
    localparam int CLK_DIV = 2;

    logic                   ATT_CLK = 1'b0;
    logic                   ATT_RST = 1'b1;
    logic [N_CH*GAIN_W-1:0] ATT_Gain = '0;
    logic [N_CH-1:0]        ATT_Mask = '0;
    logic                   ATT_Start = 1'b0;
    logic                   ATT_Busy;
    logic                   ATT_Done;
    logic                   ATT_SCLK;
    logic                   ATT_DATA;
    logic [N_CH-1:0]        ATT_LE;

    always #5 ATT_CLK = ~ATT_CLK;

    digi_att_chain #(
        .N_CH    (N_CH),
        .GAIN_W  (GAIN_W),
        .PAD_W   (PAD_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .ATT_CLK   (ATT_CLK),
        .ATT_RST   (ATT_RST),
        .ATT_Gain  (ATT_Gain),
        .ATT_Mask  (ATT_Mask),
        .ATT_Start (ATT_Start),
        .ATT_Busy  (ATT_Busy),
        .ATT_Done  (ATT_Done),
        .ATT_SCLK  (ATT_SCLK),
        .ATT_DATA  (ATT_DATA),
        .ATT_LE    (ATT_LE)
    );

    typedef struct { int ch; int word; } le_exp_t;
    typedef struct { int lat; int sclk; } done_exp_t;

    le_exp_t   le_q[$];
    done_exp_t done_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge ATT_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_le(input int ch, input int word);
        le_exp_t e;
        e.ch = ch;
        e.word = word;
        le_q.push_back(e);
    endtask

    task automatic push_done(input int lat, input int sclk);
        done_exp_t e;
        e.lat = lat;
        e.sclk = sclk;
        done_q.push_back(e);
    endtask

    task automatic start_req(input logic [N_CH*GAIN_W-1:0] gain, input logic [N_CH-1:0] mask);
        @(posedge ATT_CLK); #1;
        ATT_Gain  = gain;
        ATT_Mask  = mask;
        ATT_Start = 1'b1;
        start_cyc = cyc;
        @(posedge ATT_CLK); #1;
        ATT_Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((ATT_Busy || done_q.size() != 0) && n < 500) begin
            @(posedge ATT_CLK); #1;
            n++;
        end
        chk(name, {31'b0, (n < 500)}, 32'd1);
        repeat (2) @(posedge ATT_CLK);
    endtask

    // Monitor: reassemble serial words and compare against the scoreboard.
    logic [7:0]      mon_word = '0;
    int              mon_bits = 0;
    int              req_sclk = 0;
    int              le_len = 0;
    logic [N_CH-1:0] le_prev = '0;
    logic            sclk_prev = 1'b0;
    logic            data_prev = 1'b0;

    always @(negedge ATT_CLK) begin
        if (ATT_RST) begin
            mon_word  = '0;
            mon_bits  = 0;
            req_sclk  = 0;
            le_len    = 0;
            le_prev   = '0;
            sclk_prev = 1'b0;
            data_prev = 1'b0;
        end else begin
            if (ATT_SCLK && sclk_prev) chk("data_hold_while_sclk_high", ATT_DATA, data_prev);
            if (ATT_SCLK && !sclk_prev) begin
                mon_word = {mon_word[6:0], ATT_DATA};
                mon_bits++;
                req_sclk++;
            end
            sclk_prev = ATT_SCLK;
            data_prev = ATT_DATA;

            if (ATT_LE != '0) begin
                chk("le_onehot", {31'b0, $onehot(ATT_LE)}, 32'd1);
                if (le_prev == '0) begin
                    $display("[%0d] latch le=%b word=%02h bits=%0d", cyc, ATT_LE, mon_word, mon_bits);
                    if (le_q.size() == 0) begin
                        chk("le_unexpected", ATT_LE, 0);
                    end else begin
                        le_exp_t e;
                        e = le_q.pop_front();
                        chk("le_channel", ATT_LE, 32'd1 << e.ch);
                        chk("le_word", mon_word, e.word);
                        chk("le_bits", mon_bits, 8);
                    end
                    mon_bits = 0;
                end
                le_len++;
            end else if (le_prev != '0) begin
                chk("le_width", le_len, CLK_DIV);
                le_len = 0;
            end
            le_prev = ATT_LE;

            if (ATT_Done) begin
                $display("[%0d] done latency=%0d sclk_rises=%0d", cyc, cyc - start_cyc, req_sclk);
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {31'b0, ATT_Done}, 0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_latency", cyc - start_cyc, d.lat);
                    chk("done_sclk_count", req_sclk, d.sclk);
                    chk("done_busy", {31'b0, ATT_Busy}, 32'd1);
                end
                req_sclk = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, during and after reset.
        repeat (3) @(posedge ATT_CLK);
        #1;
        chk("reset_outputs", {ATT_SCLK, ATT_DATA, ATT_LE, ATT_Busy, ATT_Done}, 0);
        ATT_RST = 1'b0;
        @(posedge ATT_CLK); #1;
        chk("post_reset_outputs", {ATT_SCLK, ATT_DATA, ATT_LE, ATT_Busy, ATT_Done}, 0);

        // Single channel: ch0 = 101101 -> 1,0,1,1,0,1,0,0; Done at 37.
        push_le(0, 'hB4);
        push_done(37, 8);
        start_req({6'h00, 6'h00, 6'h00, 6'b101101}, 4'b0001);
        chk("sel_busy", {ATT_Busy, ATT_DATA, ATT_SCLK}, 3'b100);
        @(posedge ATT_CLK); #1;
        chk("first_bit", {ATT_DATA, ATT_SCLK}, 2'b10);
        wait_idle("wait_single");
        chk("busy_fall", {31'b0, ATT_Busy}, 0);

        // Two channels: ch1 then ch3; Done at 73.
        push_le(1, 'hA8);
        push_le(3, 'h3C);
        push_done(73, 16);
        start_req({6'h0F, 6'h00, 6'h2A, 6'h00}, 4'b1010);
        wait_idle("wait_two_ch");

        // Start during Busy with changed gain/mask is ignored; first snapshot wins.
        push_le(2, 'hCC);
        push_done(37, 8);
        start_req({6'h00, 6'h33, 6'h00, 6'h00}, 4'b0100);
        repeat (8) @(posedge ATT_CLK);
        #1;
        ATT_Gain  = {4{6'h0C}};
        ATT_Mask  = 4'b1111;
        ATT_Start = 1'b1;
        @(posedge ATT_CLK); #1;
        ATT_Start = 1'b0;
        wait_idle("wait_ignored_start");
        repeat (5) @(posedge ATT_CLK);
        #1;
        chk("no_queued_request", {31'b0, ATT_Busy}, 0);

        // Reset during SHIFT of ch2 aborts with no LE pulse.
        start_req({6'h00, 6'h15, 6'h00, 6'h00}, 4'b0100);
        repeat (10) @(posedge ATT_CLK);
        #1;
        chk("mid_shift_busy", {31'b0, ATT_Busy}, 32'd1);
        ATT_RST = 1'b1;
        #1;
        chk("reset_abort_outputs", {ATT_SCLK, ATT_DATA, ATT_LE, ATT_Busy, ATT_Done}, 0);
        repeat (2) @(posedge ATT_CLK);
        #1;
        ATT_RST = 1'b0;
        repeat (40) @(posedge ATT_CLK);
        #1;
        chk("idle_after_abort", {ATT_Busy, ATT_LE}, 0);
        push_le(2, 'h54);
        push_done(37, 8);
        start_req({6'h00, 6'h15, 6'h00, 6'h00}, 4'b0100);
        wait_idle("wait_after_reset");

        // Empty mask: Done 2 cycles after Start, no SCLK.
        push_done(2, 0);
        start_req({6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'b0000);
        wait_idle("wait_mask0");

        // All channels, extreme gains; Done at 1 + 4*36.
        push_le(0, 'hFC);
        push_le(1, 'h44);
        push_le(2, 'h04);
        push_le(3, 'h80);
        push_done(145, 32);
        start_req({6'h20, 6'h01, 6'h11, 6'h3F}, 4'b1111);
        wait_idle("wait_all_ch");

`ifdef DIGI_ATT_SKIP_UNCHANGED_EN
        // Rewriting an unchanged gain is skipped.
        push_le(0, 'h14);
        push_done(37, 8);
        start_req({6'h00, 6'h00, 6'h00, 6'h05}, 4'b0001);
        wait_idle("wait_skip_first");
        push_done(2, 0);
        start_req({6'h00, 6'h00, 6'h00, 6'h05}, 4'b0001);
        wait_idle("wait_skip_second");
`endif

        chk("le_queue_drained", le_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
